counter_scheduler: RTL

COUNTER_SCHEDULER -- requirements
Module: counter_scheduler

---
 rtl/counter_sched_pkg.sv | 14 +
 rtl/step_counter.sv | 25 ++
 rtl/counter_scheduler.sv | 126 ++++++++++++
 3 files changed

// File: rtl/counter_sched_pkg.sv
// Shared types and constants for the counter scheduler.
// Optional pause feature is enabled with COUNTER_SCHED_PAUSE_EN.
package counter_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int STEP    = 2;
    localparam int NUM_REQ = 2;

endpackage

// File: rtl/step_counter.sv
// Even-step counter: loads an even start value, then advances by STEP with natural wrap.
module step_counter
    import counter_sched_pkg::*;
#(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= {load_val[W-1:1], 1'b0};
        end else if (en) begin
            count <= count + W'(STEP);
        end
    end

endmodule

// File: rtl/counter_scheduler.sv
// Two-requester round-robin scheduler that lends an even-step counter for len steps.
// Defining COUNTER_SCHED_PAUSE_EN adds a pause input that freezes a run in progress.
//
// state | meaning
// IDLE  | no owner; arbitrate pending requests and load base/len of the winner
// RUN   | owner holds the counter; one count value per cycle (len=0 gives one empty cycle)
// DONE  | one-cycle done pulse to the owner; grant still held
module counter_scheduler
    import counter_sched_pkg::*;
#(
    parameter int COUNT_LEN = 10,
    parameter int LEN_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [COUNT_LEN:0]   base0,
    input  logic [COUNT_LEN:0]   base1,
    input  logic [LEN_W-1:0]     len0,
    input  logic [LEN_W-1:0]     len1,
`ifdef COUNTER_SCHED_PAUSE_EN
    input  logic                 pause,
`endif
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic [COUNT_LEN:0]   count,
    output logic                 count_valid,
    output logic [NUM_REQ-1:0]   done
);

    localparam int W = COUNT_LEN + 1;

    state_t           state;
    logic             owner;
    logic             last;
    logic             winner;
    logic [LEN_W-1:0] steps_left;
    logic [LEN_W-1:0] sel_len;
    logic [W-1:0]     sel_base;
    logic             pause_act;
    logic             cnt_load;
    logic             cnt_en;

`ifdef COUNTER_SCHED_PAUSE_EN
    assign pause_act = pause;
`else
    assign pause_act = 1'b0;
`endif

    // Tie goes to whoever was not served last; a lone request always wins.
    always_comb begin
        winner   = (req == 2'b11) ? ~last : req[1];
        sel_len  = winner ? len1 : len0;
        sel_base = winner ? base1 : base0;
        cnt_load = (state == IDLE) && (req != '0);
        cnt_en   = (state == RUN) && req[owner] && !pause_act && (steps_left > LEN_W'(1));
    end

    step_counter #(.W(W)) u_step_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .en       (cnt_en),
        .load_val (sel_base),
        .count    (count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= '0;
            busy        <= 1'b0;
            count_valid <= 1'b0;
            done        <= '0;
            steps_left  <= '0;
            owner       <= 1'b0;
            last        <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    done        <= '0;
                    grant       <= '0;
                    busy        <= 1'b0;
                    count_valid <= 1'b0;
                    if (req != '0) begin
                        owner       <= winner;
                        last        <= winner;
                        grant       <= winner ? 2'b10 : 2'b01;
                        busy        <= 1'b1;
                        steps_left  <= sel_len;
                        count_valid <= (sel_len != '0);
                        state       <= RUN;
                    end
                end
                RUN: begin
                    if (!req[owner]) begin
                        state       <= IDLE;
                        grant       <= '0;
                        busy        <= 1'b0;
                        count_valid <= 1'b0;
                    end else if (pause_act) begin
                        count_valid <= 1'b0;
                    end else if (steps_left <= LEN_W'(1)) begin
                        state       <= DONE;
                        done        <= grant;
                        count_valid <= 1'b0;
                        steps_left  <= '0;
                    end else begin
                        steps_left  <= steps_left - LEN_W'(1);
                        count_valid <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= '0;
                    grant <= '0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
